irq_controller: RTL

- Interrupt responder on the core side of the `irq_req`/`irq_ret` pair, instantiated in `riscv_unit` next to the LSU and memories.
- Collects `NUM_IRQ` peripheral interrupt lines and latches edge events. Applies a core-supplied mask and arbitrates by fixed priority.
- Holds `irq_req_o` to the core until the handler completes (`irq_ret_i`), then re-arbitrates.
- No nesting: exactly one interrupt is in service at a time.

---
 rtl/irq_controller.sv | 111 +++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// Core-side interrupt responder: latches edge events, masks, and picks the lowest
// eligible line by fixed priority, then holds the request until the handler returns.
module irq_controller #(
    parameter int                 NUM_IRQ   = 16,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = '1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_IRQ-1:0]         irq_lines_i,
    input  logic [NUM_IRQ-1:0]         irq_mask_i,
    input  logic                       irq_ret_i,
    input  logic                       clear_overrun_i,
    output logic                       irq_req_o,
    output logic [$clog2(NUM_IRQ)-1:0] irq_cause_o,
    output logic [NUM_IRQ-1:0]         irq_pending_o,
    output logic [NUM_IRQ-1:0]         irq_overrun_o,
    output logic                       state_o
);
    localparam int CW = $clog2(NUM_IRQ);

    // Handshake: irq_req_o rises when a line is taken into service and stays high
    // until the core pulses irq_ret_i for one cycle; irq_cause_o is stable meanwhile.
    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 req_q, req_d;
    logic [CW-1:0]        cause_q, cause_d;
    logic [NUM_IRQ-1:0]   prev_q;
    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic [NUM_IRQ-1:0]   overrun_q, overrun_d;
    logic [NUM_IRQ-1:0]   rise;
    logic [NUM_IRQ-1:0]   eff_pending;
    logic [NUM_IRQ-1:0]   eligible;
    logic [NUM_IRQ-1:0]   ret_clear;
    logic [CW-1:0]        winner;
    logic                 ret_fire;

    assign rise        = irq_lines_i & ~prev_q;
    // Level lines bypass storage and follow the raw input.
    assign eff_pending = (pending_q & EDGE_MASK) | (irq_lines_i & ~EDGE_MASK);
    assign eligible    = eff_pending & irq_mask_i;
    assign ret_fire    = (state_q == SERVICE) && irq_ret_i;

    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = CW'(i);
        end
    end

    always_comb begin
        ret_clear = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ret_clear[i] = ret_fire && (cause_q == CW'(i)) && EDGE_MASK[i];
        end
    end

    // A rise coinciding with the return re-latches the line without flagging overrun.
    assign pending_d = ((pending_q & ~ret_clear) | rise) & EDGE_MASK;
    assign overrun_d = (overrun_q & ~{NUM_IRQ{clear_overrun_i}})
                     | (rise & pending_q & ~ret_clear & EDGE_MASK);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = SERVICE;
                    req_d   = 1'b1;
                    cause_d = winner;
                end
            end
            SERVICE: begin
                if (irq_ret_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            cause_q   <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            cause_q   <= cause_d;
            prev_q    <= irq_lines_i;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign irq_req_o     = req_q;
    assign irq_cause_o   = cause_q;
    assign irq_pending_o = eff_pending;
    assign irq_overrun_o = overrun_q;
    assign state_o       = state_q;
endmodule
